riscv_tag_exc_ctrl: RTL
=======================

// Module: riscv_tag_exc_ctrl
// PURPOSE
//  Sequences DIFT tag-check violations raised by the EX stage tag check logic into a precise trap.
//  Sits beside the EX stage and the core controller. It halts fetch/decode, waits for the pipeline
//  to drain, then raises a handshaked trap request and holds fault PC/cause until the handler returns.
//  Software-visible policy: enable, count-only mode, saturating violation counter.
// PARAMETERS
//  CNT_WIDTH   16  width of saturating violation counter (2..32)
//  PC_WIDTH    32  width of captured fault PC
// PORTS
//  clk              in   1         core clock
//  rst              in   1         asynchronous reset, active-high
//  exception_i      in   1         tag check violation for instruction currently in EX
//  exc_src_i        in   3         {check_d, check_s2, check_s1} flags that fired
//  ex_valid_i       in   1         EX instruction retires into WB this cycle
//  pc_ex_i          in   PC_WIDTH  PC of instruction in EX
//  drain_done_i     in   1         LSU/WB idle: no outstanding memory op
//  irq_ack_i        in   1         controller accepted trap request
//  handler_done_i   in   1         handler return (mret) executed
//  csr_we_i         in   1         policy register write strobe
//  csr_addr_i       in   2         0 CTRL, 1 FAULT_PC, 2 CAUSE, 3 COUNT
//  csr_wdata_i      in   32        write data
//  csr_rdata_o      out  32        combinational read data for csr_addr_i
//  halt_o           out  1         stall IF/ID, block new issue into EX
//  irq_req_o        out  1         trap request to controller
//  busy_o           out  1         FSM not in IDLE
// BEHAVIOUR
//  Reset: state=IDLE; halt_o=0, irq_req_o=0, busy_o=0; CTRL=3'b001 (enabled, trap mode, no sticky).
//   FAULT_PC=0, CAUSE=0, COUNT=0.
//  CTRL bits: [0] en, [1] count_only, [2] sticky (stay halted after handler_done until CTRL write).
//   Bits [31:3] read 0 and ignore writes.
//  Violation event: viol = exception_i & ex_valid_i & en. Only sampled on ex_valid_i,
//   so a stalled EX instruction counts once.
//  COUNT: +1 per viol in any state; saturates at 2^CNT_WIDTH-1; zero-extended on read.
//   A write to addr 3 clears it. Same-cycle clear and viol -> COUNT=1.
//  FSM (registered, one transition per cycle):
//   IDLE    : viol & ~count_only -> DRAIN. Capture FAULT_PC=pc_ex_i, CAUSE[2:0]=exc_src_i, CAUSE[3]=0.
//             viol & count_only -> stay IDLE, count only.
//   DRAIN   : halt_o=1. drain_done_i -> REQ (earliest the cycle after entry; 1-cycle min dwell).
//   REQ     : halt_o=1, irq_req_o=1 held until irq_ack_i; on ack -> HANDLER. irq_req_o drops next cycle.
//   HANDLER : halt_o=0 (handler code runs). viol here sets CAUSE[3] (nested), counts, does not re-trap.
//             handler_done_i -> IDLE, or -> HALT if sticky.
//   HALT    : halt_o=1 until a CSR write to CTRL with bit2=0 -> IDLE.
//  Latency: viol at cycle N -> halt_o=1 at N+1; irq_req_o no earlier than N+2.
//  Policy changes: clearing en in DRAIN/REQ does not abort; the sequence completes. The new CTRL
//   applies to the next viol.
//  Ignored inputs: handler_done_i outside HANDLER; irq_ack_i outside REQ.
//  FAULT_PC/CAUSE: updated only on an IDLE->DRAIN transition; writes to addr 1/2 are ignored.
//  CSR write and viol in same cycle: the write takes effect for later cycles; the current viol uses
//   the old CTRL.
//  busy_o = (state != IDLE).
//  Reset asserted mid-sequence returns the block to IDLE immediately (async), all registers to
//   reset values.
// STRUCTURE
//  riscv_defines additions:
//   tag_exc_state_e {TEXC_IDLE, TEXC_DRAIN, TEXC_REQ, TEXC_HANDLER, TEXC_HALT}
//   TEXC_CSR_CTRL/FAULT_PC/CAUSE/COUNT address constants
//   CTRL bit index constants
//  Sub-module: riscv_tag_viol_counter (param WIDTH; inc, clr, saturating count out).
//  FSM, capture registers and CSR mux stay in this module.
// TESTING
//  1 Reset then viol with pc 0x0000_1040, src 3'b010 -> halt_o@+1; drain_done_i@+3 -> irq_req_o@+4;
//    ack@+6 -> HANDLER. FAULT_PC reads 0x1040, CAUSE 0x2, COUNT 1.
//  2 CTRL=3'b011 (count_only); 5 viols -> halt_o never 1, irq_req_o never 1, COUNT=5, FAULT_PC=0.
//  3 CNT_WIDTH=4: 20 viols count_only -> COUNT=15; write addr 3 concurrent with viol -> COUNT=1.
//  4 viol in HANDLER -> CAUSE[3]=1, COUNT+1, no new irq_req_o; handler_done_i with sticky=1 ->
//    HALT, halt_o=1; CTRL write 3'b001 -> IDLE next cycle.
//  5 exception_i=1 held 4 cycles with ex_valid_i=0 then 1 cycle ex_valid_i=1 -> COUNT=1, one trap.
//  6 rst pulse while in REQ -> irq_req_o=0, halt_o=0, CTRL reads 0x1, all else 0.
//    Spurious irq_ack_i in IDLE -> no change.

Source files
------------

// File: rtl/riscv_tag_exc_ctrl_pkg.sv
// Shared types and constants for the DIFT tag-exception controller:
// FSM state encoding, CSR address map and CTRL register layout.
package riscv_tag_exc_ctrl_pkg;

    typedef enum logic [2:0] {
        TEXC_IDLE,
        TEXC_DRAIN,
        TEXC_REQ,
        TEXC_HANDLER,
        TEXC_HALT
    } tag_exc_state_e;

    localparam logic [1:0] TEXC_CSR_CTRL     = 2'd0;
    localparam logic [1:0] TEXC_CSR_FAULT_PC = 2'd1;
    localparam logic [1:0] TEXC_CSR_CAUSE    = 2'd2;
    localparam logic [1:0] TEXC_CSR_COUNT    = 2'd3;

    localparam int TEXC_CTRL_EN         = 0;
    localparam int TEXC_CTRL_COUNT_ONLY = 1;
    localparam int TEXC_CTRL_STICKY     = 2;

    typedef struct packed {
        logic sticky;
        logic count_only;
        logic en;
    } tag_ctrl_t;

    localparam tag_ctrl_t TEXC_CTRL_RESET = '{sticky: 1'b0, count_only: 1'b0, en: 1'b1};

    // Extracts the three policy bits from a CSR write word; bits [31:3] have no storage.
    function automatic tag_ctrl_t ctrl_from_word(input logic [31:0] word);
        tag_ctrl_t c;
        c.en         = word[TEXC_CTRL_EN];
        c.count_only = word[TEXC_CTRL_COUNT_ONLY];
        c.sticky     = word[TEXC_CTRL_STICKY];
        return c;
    endfunction

endpackage

// File: rtl/riscv_tag_exc_ctrl_if.sv
// Pipeline, controller and CSR signals between the core and the tag-exception controller.
// The slave side is the controller; the master side is the core/environment.
interface riscv_tag_exc_ctrl_if #(
    parameter int PC_WIDTH = 32
);
    logic                exception;
    logic [2:0]          exc_src;
    logic                ex_valid;
    logic [PC_WIDTH-1:0] pc_ex;
    logic                drain_done;
    logic                irq_ack;
    logic                handler_done;
    logic                csr_we;
    logic [1:0]          csr_addr;
    logic [31:0]         csr_wdata;
    logic [31:0]         csr_rdata;
    logic                halt;
    logic                irq_req;
    logic                busy;

    modport master (
        output exception, exc_src, ex_valid, pc_ex, drain_done, irq_ack,
               handler_done, csr_we, csr_addr, csr_wdata,
        input  csr_rdata, halt, irq_req, busy
    );

    modport slave (
        input  exception, exc_src, ex_valid, pc_ex, drain_done, irq_ack,
               handler_done, csr_we, csr_addr, csr_wdata,
        output csr_rdata, halt, irq_req, busy
    );
endinterface

// File: rtl/riscv_tag_viol_counter.sv
// Saturating violation counter. A clear coinciding with an increment
// leaves the count at one so that the concurrent event is not lost.
module riscv_tag_viol_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic saturated;
    assign saturated = &count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? ONE : '0;
        end else if (inc && !saturated) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/riscv_tag_exc_ctrl.sv
// Turns EX-stage DIFT tag-check violations into a precise, handshaked trap:
// halt issue, wait for drain, request the trap, hold fault PC/cause for the handler.
module riscv_tag_exc_ctrl
    import riscv_tag_exc_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 16,
    parameter int PC_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    riscv_tag_exc_ctrl_if.slave  bus
);

    tag_exc_state_e      state;
    tag_exc_state_e      state_next;
    tag_ctrl_t           ctrl;
    logic [PC_WIDTH-1:0] fault_pc;
    logic [3:0]          cause;
    logic [CNT_WIDTH-1:0] count;

    logic viol;
    logic ctrl_we;
    logic count_clr;
    logic trap_start;
    logic halt;
    logic irq_req;
    logic [31:0] rdata;
    logic unused_wdata;

    // A stalled EX instruction is only counted when it actually retires.
    assign viol      = bus.exception & bus.ex_valid & ctrl.en;
    assign ctrl_we   = bus.csr_we && (bus.csr_addr == TEXC_CSR_CTRL);
    assign count_clr = bus.csr_we && (bus.csr_addr == TEXC_CSR_COUNT);

    assign unused_wdata = ^bus.csr_wdata[31:3];

    riscv_tag_viol_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_viol_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (viol),
        .clr   (count_clr),
        .count (count)
    );

    // NOTE: every register, including the capture registers, is reset so the
    // handler never observes stale fault state after a mid-sequence reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= TEXC_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: all outputs of this block get a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        halt       = 1'b0;
        irq_req    = 1'b0;
        trap_start = 1'b0;
        unique case (state)
            TEXC_IDLE: begin
                if (viol && !ctrl.count_only) begin
                    state_next = TEXC_DRAIN;
                    trap_start = 1'b1;
                end
            end
            TEXC_DRAIN: begin
                halt = 1'b1;
                if (bus.drain_done) begin
                    state_next = TEXC_REQ;
                end
            end
            TEXC_REQ: begin
                halt    = 1'b1;
                irq_req = 1'b1;
                if (bus.irq_ack) begin
                    state_next = TEXC_HANDLER;
                end
            end
            TEXC_HANDLER: begin
                if (bus.handler_done) begin
                    state_next = ctrl.sticky ? TEXC_HALT : TEXC_IDLE;
                end
            end
            TEXC_HALT: begin
                halt = 1'b1;
                if (ctrl_we && !bus.csr_wdata[TEXC_CTRL_STICKY]) begin
                    state_next = TEXC_IDLE;
                end
            end
            default: begin
                state_next = TEXC_IDLE;
            end
        endcase
    end

    // Policy register and fault capture; a CTRL write only affects later cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl     <= TEXC_CTRL_RESET;
            fault_pc <= '0;
            cause    <= '0;
        end else begin
            if (ctrl_we) begin
                ctrl <= ctrl_from_word(bus.csr_wdata);
            end
            if (trap_start) begin
                fault_pc <= bus.pc_ex;
                cause    <= {1'b0, bus.exc_src};
            end else if (state == TEXC_HANDLER && viol) begin
                cause[3] <= 1'b1;
            end
        end
    end

    always_comb begin
        rdata = '0;
        unique case (bus.csr_addr)
            TEXC_CSR_CTRL:     rdata = 32'(ctrl);
            TEXC_CSR_FAULT_PC: rdata = 32'(fault_pc);
            TEXC_CSR_CAUSE:    rdata = 32'(cause);
            TEXC_CSR_COUNT:    rdata = 32'(count);
            default:           rdata = '0;
        endcase
    end

    assign bus.csr_rdata = rdata;
    assign bus.halt      = halt;
    assign bus.irq_req   = irq_req;
    assign bus.busy      = (state != TEXC_IDLE);

endmodule
